// File: rtl/mem_access_ctrl.sv
// Purpose: MEM-stage load/store engine; formats stores, aligns/extends loads over a req/ack bus.
// Latency: N+2 cycles in MEM (N = cycles from bus_req to bus_ack); TIMEOUT+2 cycles on abort.
// Backpressure: stallreq holds the pipeline while an aligned access is pending; bus_req held until ack or timeout.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   mem_wd/mem_wreg/mem_wdata     write-back fields from EX/MEM
//   mem_aluop/mem_mem_addr/mem_reg2  access op, effective address, store operand
//   wb_wd/wb_wreg/wb_wdata        write-back fields to MEM/WB
//   stallreq                      stall request to the pipeline controller
//   bus_req/we/addr/sel/wdata     registered data-memory request fields
//   bus_rdata/bus_ack             read data and one-cycle completion strobe
//   align_err                     misaligned op present (combinational)
//   bus_err                       one-cycle pulse on timeout abort
`timescale 1ns/1ps
module mem_access_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_mem_addr,
    input  logic [31:0] mem_reg2,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        stallreq,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        align_err,
    output logic        bus_err
);
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
    localparam logic [4:0] NOP_REG_ADDR = 5'b00000;

    // Counter value on the last BUSY cycle allowed before abort, so bus_req
    // stays high for exactly TIMEOUT cycles when no ack arrives.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic        aborted;
    logic [7:0]  op_q;
    logic [1:0]  lane_q;
    logic [31:0] rdata_q;

    logic        is_load, is_store, misalign, mem_go;
    logic [3:0]  sel_c;
    logic [31:0] wdata_c;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_val;

    // Op decode: byte selects, replicated store data, alignment check.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        misalign = 1'b0;
        sel_c    = 4'b0000;
        wdata_c  = 32'h0;
        case (mem_aluop)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
                sel_c   = 4'b0001 << mem_mem_addr[1:0];
                wdata_c = {4{mem_reg2[7:0]}};
            end
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
                sel_c    = mem_mem_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c  = {2{mem_reg2[15:0]}};
                misalign = mem_mem_addr[0];
            end
            EXE_LW_OP, EXE_SW_OP: begin
                sel_c    = 4'b1111;
                wdata_c  = mem_reg2;
                misalign = |mem_mem_addr[1:0];
            end
            default: ;
        endcase
        case (mem_aluop)
            EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: is_load = 1'b1;
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP:                         is_store = 1'b1;
            default: ;
        endcase
        mem_go = (is_load | is_store) & ~misalign;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (mem_go) state_nxt = ST_BUSY;
            ST_BUSY: if (bus_ack || cnt == CNT_LAST) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bus request fields and access bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_sel   <= 4'b0000;
            bus_wdata <= 32'h0;
            bus_err   <= 1'b0;
            cnt       <= 8'h0;
            aborted   <= 1'b0;
            op_q      <= 8'h0;
            lane_q    <= 2'b00;
            rdata_q   <= 32'h0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mem_go) begin
                        bus_req   <= 1'b1;
                        bus_we    <= is_store;
                        bus_addr  <= {mem_mem_addr[31:2], 2'b00};
                        bus_sel   <= sel_c;
                        bus_wdata <= wdata_c;
                        op_q      <= mem_aluop;
                        lane_q    <= mem_mem_addr[1:0];
                        cnt       <= 8'h0;
                        aborted   <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (bus_ack) begin
                        rdata_q <= bus_rdata;
                        bus_req <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        bus_req <= 1'b0;
                        bus_err <= 1'b1;
                        aborted <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'h1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Little-endian lane extraction from the captured word.
    always_comb begin
        case (lane_q)
            2'd1:    lane_byte = rdata_q[15:8];
            2'd2:    lane_byte = rdata_q[23:16];
            2'd3:    lane_byte = rdata_q[31:24];
            default: lane_byte = rdata_q[7:0];
        endcase
        lane_half = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (op_q)
            EXE_LB_OP:  load_val = {{24{lane_byte[7]}}, lane_byte};
            EXE_LBU_OP: load_val = {24'h0, lane_byte};
            EXE_LH_OP:  load_val = {{16{lane_half[15]}}, lane_half};
            EXE_LHU_OP: load_val = {16'h0, lane_half};
            default:    load_val = rdata_q;
        endcase
    end

    // Write-back and pipeline-facing outputs; the load result is only
    // exposed in DONE, the cycle the pipeline advances.
    always_comb begin
        wb_wd     = mem_wd;
        wb_wreg   = mem_wreg;
        wb_wdata  = mem_wdata;
        stallreq  = 1'b0;
        align_err = 1'b0;
        if (rst) begin
            wb_wd    = NOP_REG_ADDR;
            wb_wreg  = 1'b0;
            wb_wdata = 32'h0;
        end else if (is_load | is_store) begin
            wb_wreg  = 1'b0;
            wb_wdata = 32'h0;
            if (misalign) begin
                align_err = 1'b1;
            end else begin
                stallreq = (state != ST_DONE);
                if (state == ST_DONE && is_load && !aborted) begin
                    wb_wreg  = mem_wreg;
                    wb_wdata = load_val;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
`timescale 1ns/1ps
module tb_mem_access_ctrl;
    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;
    localparam logic [7:0] OP_OR  = 8'h25;
    localparam logic [7:0] OP_ADD = 8'h20;
    localparam logic [7:0] OP_NOP = 8'h00;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        stallreq;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        align_err;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .stallreq(stallreq),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_sel(bus_sel), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .align_err(align_err), .bus_err(bus_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                          input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
        mem_aluop    = op;
        mem_mem_addr = addr;
        mem_reg2     = reg2;
        mem_wd       = wd;
        mem_wreg     = wreg;
        mem_wdata    = wdata;
    endtask

    // Single-cycle vectors that never start an access (non-memory or misaligned).
    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        exp_align;
        logic        exp_wreg;
        logic        chk_wdata;
    } cv_t;

    // Full accesses; d = index of the bus_req cycle in which ack is driven.
    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [31:0] rdata;
        int          d;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] bwdata;
        logic        exp_wreg;
        logic [31:0] exp_wdata;
    } txn_t;

    cv_t  cv[8];
    txn_t tv[10];

    task automatic run_txn(input txn_t t, input logic [4:0] wd);
        logic [31:0] exp_addr;
        exp_addr = t.addr & 32'hFFFF_FFFC;
        @(negedge clk);
        set_op(t.op, t.addr, t.reg2, wd, 1'b1, 32'h5555_AAAA);
        bus_ack = 1'b0;
        #1;
        chk("c0_stall", 32'(stallreq), 32'd1);
        chk("c0_wreg", 32'(wb_wreg), 32'd0);
        for (int k = 0; k <= t.d; k++) begin
            @(negedge clk);
            if (k == t.d) begin
                bus_ack   = 1'b1;
                bus_rdata = t.rdata;
            end
            #1;
            chk("busy_req", 32'(bus_req), 32'd1);
            chk("busy_stall", 32'(stallreq), 32'd1);
            chk("busy_addr", bus_addr, exp_addr);
            chk("busy_sel", 32'(bus_sel), 32'(t.sel));
            chk("busy_we", 32'(bus_we), 32'(t.we));
            if (t.we) chk("busy_wdata", bus_wdata, t.bwdata);
        end
        @(negedge clk);
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        #1;
        chk("done_stall", 32'(stallreq), 32'd0);
        chk("done_req", 32'(bus_req), 32'd0);
        chk("done_berr", 32'(bus_err), 32'd0);
        chk("done_wreg", 32'(wb_wreg), 32'(t.exp_wreg));
        chk("done_wd", 32'(wb_wd), 32'(wd));
        if (!t.we) chk("done_wdata", wb_wdata, t.exp_wdata);
    endtask

    initial begin
        cv[0] = '{OP_OR,  32'h0000_0000, 5'd3,  1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b1};
        cv[1] = '{OP_NOP, 32'h0000_0000, 5'd0,  1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        cv[2] = '{OP_ADD, 32'h0000_0101, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1};
        cv[3] = '{OP_LW,  32'h0000_0101, 5'd4,  1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        cv[4] = '{OP_SW,  32'h0000_0102, 5'd5,  1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        cv[5] = '{OP_LH,  32'h0000_0103, 5'd6,  1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        cv[6] = '{OP_LHU, 32'h0000_0101, 5'd7,  1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        cv[7] = '{OP_SH,  32'h0000_0201, 5'd8,  1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0};

        tv[0] = '{OP_LW,  32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1, 1'b0, 4'b1111, 32'h0, 1'b1, 32'hDEAD_BEEF};
        tv[1] = '{OP_LB,  32'h0000_0103, 32'h0, 32'h8011_2233, 0, 1'b0, 4'b1000, 32'h0, 1'b1, 32'hFFFF_FF80};
        tv[2] = '{OP_LBU, 32'h0000_0103, 32'h0, 32'h8011_2233, 0, 1'b0, 4'b1000, 32'h0, 1'b1, 32'h0000_0080};
        tv[3] = '{OP_LH,  32'h0000_0102, 32'h0, 32'h8011_2233, 1, 1'b0, 4'b1100, 32'h0, 1'b1, 32'hFFFF_8011};
        tv[4] = '{OP_LHU, 32'h0000_0100, 32'h0, 32'h8011_9233, 0, 1'b0, 4'b0011, 32'h0, 1'b1, 32'h0000_9233};
        tv[5] = '{OP_LB,  32'h0000_0101, 32'h0, 32'h8011_2233, 0, 1'b0, 4'b0010, 32'h0, 1'b1, 32'h0000_0022};
        tv[6] = '{OP_SH,  32'h0000_0202, 32'h1234_ABCD, 32'h0, 0, 1'b1, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0};
        tv[7] = '{OP_SB,  32'h0000_0305, 32'h0000_00A5, 32'h0, 2, 1'b1, 4'b0010, 32'hA5A5_A5A5, 1'b0, 32'h0};
        tv[8] = '{OP_SW,  32'h0000_0400, 32'hCAFE_F00D, 32'h0, 0, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0};
        tv[9] = '{OP_LB,  32'h0000_0100, 32'h0, 32'h0000_007F, 1, 1'b0, 4'b0001, 32'h0, 1'b1, 32'h0000_007F};

        // Reset state, with a misaligned op present to show reset gating.
        rst       = 1'b1;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        set_op(OP_LW, 32'h0000_0101, 32'h0, 5'd7, 1'b1, 32'h1111_2222);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_wb_wd", 32'(wb_wd), 32'd0);
        chk("rst_wb_wreg", 32'(wb_wreg), 32'd0);
        chk("rst_wb_wdata", wb_wdata, 32'h0);
        chk("rst_stall", 32'(stallreq), 32'd0);
        chk("rst_align", 32'(align_err), 32'd0);
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_we", 32'(bus_we), 32'd0);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_sel", 32'(bus_sel), 32'd0);
        chk("rst_wdata", bus_wdata, 32'h0);
        chk("rst_berr", 32'(bus_err), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_op(cv[i].op, cv[i].addr, 32'h1234_ABCD, cv[i].wd, cv[i].wreg, cv[i].wdata);
            #1;
            chk("cv_align", 32'(align_err), 32'(cv[i].exp_align));
            chk("cv_stall", 32'(stallreq), 32'd0);
            chk("cv_wreg", 32'(wb_wreg), 32'(cv[i].exp_wreg));
            chk("cv_wd", 32'(wb_wd), 32'(cv[i].wd));
            if (cv[i].chk_wdata) chk("cv_wdata", wb_wdata, cv[i].wdata);
            @(posedge clk);
            #1;
            chk("cv_noreq", 32'(bus_req), 32'd0);
        end

        // Back-to-back accesses: each new op arrives in the IDLE cycle after DONE.
        for (int i = 0; i < 10; i++) run_txn(tv[i], 5'(i + 1));

        // Timeout with TIMEOUT=4 and no ack.
        @(negedge clk);
        set_op(OP_LW, 32'h0000_0500, 32'h0, 5'd9, 1'b1, 32'h0);
        bus_ack = 1'b0;
        #1;
        chk("to_c0_stall", 32'(stallreq), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk("to_req", 32'(bus_req), 32'd1);
            chk("to_berr_early", 32'(bus_err), 32'd0);
            chk("to_stall", 32'(stallreq), 32'd1);
        end
        @(negedge clk);
        #1;
        chk("to_done_req", 32'(bus_req), 32'd0);
        chk("to_done_berr", 32'(bus_err), 32'd1);
        chk("to_done_stall", 32'(stallreq), 32'd0);
        chk("to_done_wreg", 32'(wb_wreg), 32'd0);
        chk("to_done_wdata", wb_wdata, 32'h0);
        @(negedge clk);
        set_op(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        #1;
        chk("to_berr_once", 32'(bus_err), 32'd0);
        chk("to_idle_req", 32'(bus_req), 32'd0);

        // Reset in BUSY, then a late ack.
        @(negedge clk);
        set_op(OP_LW, 32'h0000_0100, 32'h0, 5'd10, 1'b1, 32'h0);
        #1;
        @(negedge clk);
        #1;
        chk("rb_req_before", 32'(bus_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rb_req", 32'(bus_req), 32'd0);
        chk("rb_addr", bus_addr, 32'h0);
        chk("rb_sel", 32'(bus_sel), 32'd0);
        chk("rb_stall", 32'(stallreq), 32'd0);
        chk("rb_wb_wd", 32'(wb_wd), 32'd0);
        chk("rb_wreg", 32'(wb_wreg), 32'd0);
        rst = 1'b0;
        set_op(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        bus_ack   = 1'b1;
        bus_rdata = 32'h1111_1111;
        @(negedge clk);
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        #1;
        chk("rb_ack_req", 32'(bus_req), 32'd0);
        chk("rb_ack_berr", 32'(bus_err), 32'd0);
        chk("rb_ack_stall", 32'(stallreq), 32'd0);
        chk("rb_ack_wreg", 32'(wb_wreg), 32'd0);
        run_txn(tv[0], 5'd11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

MEM-stage load/store engine that consumes the memory-access fields latched by the EX/MEM pipeline register (aluop, effective address, store operand) and performs the data access over a req/ack data-memory bus. It formats store data and byte selects, aligns and sign/zero-extends load data, and raises a stall request to the pipeline controller while an access is outstanding. It also aborts on misalignment or bus timeout. It sits between EX/MEM and MEM/WB and drives the `wb_*` write-back fields.

## Interface
- `TIMEOUT`, default 255: maximum cycles in BUSY waiting for `bus_ack` before abort; range 1..255.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `mem_wd`  in  `RegAddrBus`  destination register from EX/MEM.
- `mem_wreg`  in  1  write enable from EX/MEM.
- `mem_wdata`  in  `RegBus`  ALU result from EX/MEM.
- `mem_aluop`  in  `AluOpBus`  operation code; load/store ops are `EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP`.
- `mem_mem_addr`  in  32  effective address.
- `mem_reg2`  in  32  store operand.
- `wb_wd`  out  `RegAddrBus`  destination to MEM/WB.
- `wb_wreg`  out  1  write enable to MEM/WB.
- `wb_wdata`  out  32  write-back value.
- `stallreq`  out  1  stall request to ctrl; combinational.
- `bus_req`  out  1  access request; registered.
- `bus_we`  out  1  1 = store; registered.
- `bus_addr`  out  32  word address, `{addr[31:2],2'b00}`; registered.
- `bus_sel`  out  4  byte enables; registered.
- `bus_wdata`  out  32  store data; registered.
- `bus_rdata`  in  32  read data; valid with `bus_ack`.
- `bus_ack`  in  1  one-cycle completion strobe.
- `align_err`  out  1  misaligned access this cycle; combinational.
- `bus_err`  out  1  one-cycle pulse on timeout abort.

## Operation
- Byte order is little-endian.
  - Byte selects by `addr[1:0]`: 00→0001, 01→0010, 10→0100, 11→1000.
  - Halfword selects: `addr[1]` = 0→0011, 1→1100. Word selects: 1111.
  - Store data is replicated: SB `{4{reg2[7:0]}}`, SH `{2{reg2[15:0]}}`, SW `reg2`.
- Misaligned accesses: LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0.
  - No bus access and `stallreq`=0.
  - `align_err`=1 while the op is present.
  - `wb_wreg`=0.
- Non-memory aluop: `wb_*` = `mem_*` passthrough, `stallreq`=0, FSM stays IDLE.
- FSM states are IDLE, BUSY, DONE.
  - **IDLE**, aligned memory op present: latch addr, sel, wdata, we and aluop; set `bus_req`=1; clear the timeout counter; go to BUSY.
  - **BUSY**: hold `bus_req` and the bus fields stable. Each cycle without ack, increment the counter.
    - On `bus_ack`: capture `bus_rdata`, set `bus_req`=0, go to DONE.
    - When the counter reaches `TIMEOUT` without ack: set `bus_req`=0, pulse `bus_err`, mark the access aborted, go to DONE.
  - **DONE**: lasts one cycle, then go to IDLE. The pipeline advances on this edge.
- `stallreq` = aligned memory op present AND state ≠ DONE.
- Write-back:
  - Loads in DONE: `wb_wdata` = extracted lane. LB/LH sign-extend; LBU/LHU zero-extend; LW is the full word. `wb_wreg`=`mem_wreg`.
  - Stores: `wb_wreg`=0.
  - Aborted access: `wb_wreg`=0, `wb_wdata`=0.
  - Loads before DONE: `wb_wreg`=0.
- `bus_ack` outside BUSY is ignored.
- `rst`=1 forces:
  - state = IDLE, `bus_req`=0, `bus_we`=0;
  - `bus_addr`, `bus_sel` and `bus_wdata` = 0;
  - counter = 0, `bus_err`=0;
  - `wb_wd`=`NOPRegAddr`, `wb_wreg`=0, `wb_wdata`=0, `stallreq`=0, `align_err`=0.
- Reset asserted in BUSY drops `bus_req` at that edge. A late ack is then ignored.

## Timing
- Access latency is N+2 cycles, where N is the number of cycles from `bus_req` to `bus_ack`. Zero-wait memory (ack the cycle after req) gives 3 cycles in MEM.
  - Cycle 0: op arrives, `stallreq`=1.
  - Cycle 1: `bus_req`=1.
  - Ack cycle: capture.
  - Next cycle: DONE, `stallreq`=0, result valid.
- Bus fields are stable from `bus_req` rise until the ack edge.
- Worst case with no ack: `TIMEOUT`+2 cycles, with `bus_err` high in the DONE cycle.
- Back-to-back memory ops: DONE → IDLE → new BUSY. Minimum 1 idle cycle between requests.

## Test plan
- LW at 0x100, mem[0x100]=0xDEADBEEF, ack 2 cycles after req → `bus_sel`=1111, `stallreq` high 3 cycles, then `wb_wdata`=0xDEADBEEF with `wb_wreg`=1 in DONE.
- LB at 0x103, word 0x80112233 → `bus_sel`=1000, `wb_wdata`=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x202, `reg2`=0x1234ABCD → `bus_we`=1, `bus_sel`=1100, `bus_wdata`=0xABCDABCD, `wb_wreg`=0.
- LW at 0x101 → no `bus_req`, `align_err`=1, `stallreq`=0, `wb_wreg`=0.
- `TIMEOUT`=4, ack never asserted → `bus_req` high 4 cycles, then low. `bus_err` pulses once, `wb_wreg`=0, FSM returns to IDLE.
- `rst` asserted during BUSY, ack arriving the next cycle → `bus_req`=0 after the reset edge, all outputs at reset values, ack ignored, FSM in IDLE.
